// File: rtl/div_ctrl_pkg.sv
// Shared types and constants for the radix-2 restoring divider controller.
package div_ctrl_pkg;

   localparam int unsigned DIV_DATA_W = 32;
   localparam int unsigned DIV_CNT_W  = 6;

   typedef enum logic [1:0] {
      DIV_FREE    = 2'b00,
      DIV_BY_ZERO = 2'b01,
      DIV_ON      = 2'b10,
      DIV_END     = 2'b11
   } div_state_e;

   localparam logic DIV_RESULT_READY     = 1'b1;
   localparam logic DIV_RESULT_NOT_READY = 1'b0;
   localparam logic DIV_START            = 1'b1;
   localparam logic DIV_STOP             = 1'b0;

endpackage

// File: rtl/div_ctrl_if.sv
// EX <-> divider request/response bundle.
interface div_ctrl_if #(
   parameter int unsigned DATA_W = div_ctrl_pkg::DIV_DATA_W
);
   logic                  start;
   logic                  signed_div;
   logic [DATA_W-1:0]     opdata1;
   logic [DATA_W-1:0]     opdata2;
   logic                  annul;
   logic [2*DATA_W-1:0]   result;
   logic                  ready;
   logic                  stallreq;

   modport master (
      output start, signed_div, opdata1, opdata2, annul,
      input  result, ready, stallreq
   );

   modport slave (
      input  start, signed_div, opdata1, opdata2, annul,
      output result, ready, stallreq
   );
endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, conditionally subtract.
module div_step #(
   parameter int unsigned DATA_W = 32
) (
   input  logic [DATA_W-1:0] rem,
   input  logic              dividend_bit,
   input  logic [DATA_W-1:0] divisor,
   output logic [DATA_W-1:0] rem_nxt,
   output logic              q_bit
);
   logic [DATA_W:0] shifted;
   logic [DATA_W:0] diff;

   // rem < divisor, so a non-negative diff always fits in DATA_W bits;
   // the extra MSB acts as the borrow flag.
   assign shifted = {rem, dividend_bit};
   assign diff    = shifted - {1'b0, divisor};
   assign q_bit   = ~diff[DATA_W];
   assign rem_nxt = q_bit ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle signed/unsigned divider controller returning {remainder, quotient}.
module div_ctrl
   import div_ctrl_pkg::*;
#(
   parameter int unsigned DATA_W = DIV_DATA_W,
   parameter int unsigned CNT_W  = DIV_CNT_W
) (
   input  logic       clk,
   input  logic       resetn,
   div_ctrl_if.slave  bus
);
   div_state_e            state;
   logic [CNT_W-1:0]      cnt;
   logic [DATA_W-1:0]     dividend;
   logic [DATA_W-1:0]     divisor;
   logic [DATA_W-1:0]     rem;
   logic                  sign1;
   logic                  sign2;
   logic [2*DATA_W-1:0]   result;
   logic                  ready;

   logic                  req;
   logic [DATA_W-1:0]     op1_abs;
   logic [DATA_W-1:0]     op2_abs;
   logic [DATA_W-1:0]     rem_nxt;
   logic                  q_bit;
   logic [DATA_W-1:0]     quo_nxt;
   logic [DATA_W-1:0]     quo_fix;
   logic [DATA_W-1:0]     rem_fix;

   assign req     = (bus.start == DIV_START) & ~bus.annul;
   assign op1_abs = bus.opdata1[DATA_W-1] ? DATA_W'('0) - bus.opdata1 : bus.opdata1;
   assign op2_abs = bus.opdata2[DATA_W-1] ? DATA_W'('0) - bus.opdata2 : bus.opdata2;

   div_step #(.DATA_W(DATA_W)) u_step (
      .rem          (rem),
      .dividend_bit (dividend[DATA_W-1]),
      .divisor      (divisor),
      .rem_nxt      (rem_nxt),
      .q_bit        (q_bit)
   );

   // Quotient bits shift into the dividend register as its bits are consumed.
   assign quo_nxt = {dividend[DATA_W-2:0], q_bit};
   assign quo_fix = (sign1 ^ sign2) ? DATA_W'('0) - quo_nxt : quo_nxt;
   assign rem_fix = sign1 ? DATA_W'('0) - rem_nxt : rem_nxt;

   assign bus.stallreq = ((state == DIV_FREE) & req) | (state == DIV_ON) | (state == DIV_BY_ZERO);
   assign bus.result   = result;
   assign bus.ready    = ready;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state    <= DIV_FREE;
         cnt      <= '0;
         dividend <= '0;
         divisor  <= '0;
         rem      <= '0;
         sign1    <= 1'b0;
         sign2    <= 1'b0;
         result   <= '0;
         ready    <= DIV_RESULT_NOT_READY;
      end else begin
         ready <= DIV_RESULT_NOT_READY;
         case (state)
            DIV_FREE: begin
               if (req) begin
                  cnt <= '0;
                  rem <= '0;
                  if (bus.opdata2 == '0) begin
                     // Raw dividend is kept for the divide-by-zero result.
                     state    <= DIV_BY_ZERO;
                     dividend <= bus.opdata1;
                     divisor  <= bus.opdata2;
                     sign1    <= 1'b0;
                     sign2    <= 1'b0;
                  end else if (bus.signed_div) begin
                     state    <= DIV_ON;
                     dividend <= op1_abs;
                     divisor  <= op2_abs;
                     sign1    <= bus.opdata1[DATA_W-1];
                     sign2    <= bus.opdata2[DATA_W-1];
                  end else begin
                     state    <= DIV_ON;
                     dividend <= bus.opdata1;
                     divisor  <= bus.opdata2;
                     sign1    <= 1'b0;
                     sign2    <= 1'b0;
                  end
               end
            end
            DIV_BY_ZERO: begin
               if (bus.annul) begin
                  state <= DIV_FREE;
               end else begin
                  result <= {dividend, {DATA_W{1'b1}}};
                  ready  <= DIV_RESULT_READY;
                  state  <= DIV_END;
               end
            end
            DIV_ON: begin
               if (bus.annul) begin
                  state <= DIV_FREE;
               end else begin
                  rem      <= rem_nxt;
                  dividend <= quo_nxt;
                  cnt      <= cnt + CNT_W'(1);
                  if (cnt == CNT_W'(DATA_W - 1)) begin
                     result <= {rem_fix, quo_fix};
                     ready  <= DIV_RESULT_READY;
                     state  <= DIV_END;
                  end
               end
            end
            DIV_END: begin
               state <= DIV_FREE;
            end
            default: begin
               state <= DIV_FREE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_div_ctrl.sv
// Directed self-checking bench for div_ctrl.
module tb_div_ctrl;
   logic clk    = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   div_ctrl_if #(.DATA_W(32)) bus ();

   div_ctrl u_dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus.slave)
   );

   int          n_checks = 0;
   int          n_fail   = 0;
   int          r_lat;
   int          r_stall_bad;
   logic        r_stall_end;
   logic        r_ready_after;
   logic        r_ready_seen;
   logic [63:0] r_res;

   // Drive one request from an IDLE cycle; returns one cycle after ready.
   task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sgn);
      bus.opdata1    = a;
      bus.opdata2    = b;
      bus.signed_div = sgn;
      bus.start      = 1'b1;
      #1;
      r_stall_bad  = bus.stallreq ? 0 : 1;
      r_lat        = 0;
      r_ready_seen = 1'b0;
      while (r_lat < 60) begin
         @(posedge clk); #1;
         r_lat++;
         if (bus.ready) begin
            r_ready_seen = 1'b1;
            break;
         end
         if (!bus.stallreq) r_stall_bad++;
      end
      r_res       = bus.result;
      r_stall_end = bus.stallreq;
      bus.start   = 1'b0;
      @(posedge clk); #1;
      r_ready_after = bus.ready;
   endtask

   task automatic test_reset();
      bus.start = 1'b0; bus.annul = 1'b0; bus.signed_div = 1'b0;
      bus.opdata1 = '0; bus.opdata2 = '0;
      #2;
      n_checks++; if (bus.ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", bus.ready); end
      n_checks++; if (bus.result !== 64'h0) begin n_fail++; $display("FAIL reset_result: got %h expected 0", bus.result); end
      n_checks++; if (bus.stallreq !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", bus.stallreq); end
      @(posedge clk); #1; resetn = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_unsigned();
      run_div(32'd100, 32'd7, 1'b0);
      n_checks++; if (r_lat !== 33) begin n_fail++; $display("FAIL udiv_latency: got %0d expected 33", r_lat); end
      n_checks++; if (r_res !== {32'd2, 32'd14}) begin n_fail++; $display("FAIL udiv_result: got %h expected %h", r_res, {32'd2, 32'd14}); end
      n_checks++; if (r_stall_bad !== 0) begin n_fail++; $display("FAIL udiv_stall: %0d cycles low, expected 0", r_stall_bad); end
      n_checks++; if (r_stall_end !== 1'b0) begin n_fail++; $display("FAIL udiv_stall_end: got %b expected 0", r_stall_end); end
      n_checks++; if (r_ready_after !== 1'b0) begin n_fail++; $display("FAIL udiv_ready_pulse: got %b expected 0", r_ready_after); end
      run_div(32'hFFFF_FFFF, 32'd1, 1'b0);
      n_checks++; if (r_res !== {32'h0, 32'hFFFF_FFFF}) begin n_fail++; $display("FAIL udiv_max: got %h expected %h", r_res, {32'h0, 32'hFFFF_FFFF}); end
   endtask

   task automatic test_signed();
      run_div(32'hFFFF_FFF9, 32'd2, 1'b1);
      n_checks++; if (r_lat !== 33) begin n_fail++; $display("FAIL sdiv_latency: got %0d expected 33", r_lat); end
      n_checks++; if (r_res !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin n_fail++; $display("FAIL sdiv_neg_pos: got %h expected %h", r_res, {32'hFFFF_FFFF, 32'hFFFF_FFFD}); end
      run_div(32'd7, 32'hFFFF_FFFE, 1'b1);
      n_checks++; if (r_res !== {32'd1, 32'hFFFF_FFFD}) begin n_fail++; $display("FAIL sdiv_pos_neg: got %h expected %h", r_res, {32'd1, 32'hFFFF_FFFD}); end
      run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
      n_checks++; if (r_res !== {32'h0, 32'h8000_0000}) begin n_fail++; $display("FAIL sdiv_overflow: got %h expected %h", r_res, {32'h0, 32'h8000_0000}); end
   endtask

   task automatic test_div_zero();
      run_div(32'h1234_5678, 32'h0, 1'b0);
      n_checks++; if (r_lat !== 2) begin n_fail++; $display("FAIL dz_latency: got %0d expected 2", r_lat); end
      n_checks++; if (r_res !== {32'h1234_5678, 32'hFFFF_FFFF}) begin n_fail++; $display("FAIL dz_result: got %h expected %h", r_res, {32'h1234_5678, 32'hFFFF_FFFF}); end
      n_checks++; if (r_stall_bad !== 0) begin n_fail++; $display("FAIL dz_stall: %0d cycles low, expected 0", r_stall_bad); end
      run_div(32'hFFFF_FFF9, 32'h0, 1'b1);
      n_checks++; if (r_res !== {32'hFFFF_FFF9, 32'hFFFF_FFFF}) begin n_fail++; $display("FAIL dz_signed_raw: got %h expected %h", r_res, {32'hFFFF_FFF9, 32'hFFFF_FFFF}); end
   endtask

   task automatic test_annul();
      int ready_cnt = 0;
      bus.opdata1 = 32'd1000; bus.opdata2 = 32'd3; bus.signed_div = 1'b0; bus.start = 1'b1;
      for (int i = 0; i < 10; i++) begin @(posedge clk); #1; end
      bus.annul = 1'b1; bus.start = 1'b0;
      @(posedge clk); #1;
      bus.annul = 1'b0;
      n_checks++; if (bus.stallreq !== 1'b0) begin n_fail++; $display("FAIL annul_idle: stallreq %b expected 0", bus.stallreq); end
      for (int i = 0; i < 40; i++) begin @(posedge clk); #1; if (bus.ready) ready_cnt++; end
      n_checks++; if (ready_cnt !== 0) begin n_fail++; $display("FAIL annul_no_ready: got %0d pulses expected 0", ready_cnt); end
      n_checks++; if (bus.result !== {32'hFFFF_FFF9, 32'hFFFF_FFFF}) begin n_fail++; $display("FAIL annul_result_held: got %h expected %h", bus.result, {32'hFFFF_FFF9, 32'hFFFF_FFFF}); end
      // start together with annul in IDLE is dropped
      bus.opdata1 = 32'd20; bus.opdata2 = 32'd4; bus.start = 1'b1; bus.annul = 1'b1;
      #1;
      n_checks++; if (bus.stallreq !== 1'b0) begin n_fail++; $display("FAIL annul_idle_stall: got %b expected 0", bus.stallreq); end
      ready_cnt = 0;
      for (int i = 0; i < 5; i++) begin @(posedge clk); #1; if (bus.ready || bus.stallreq) ready_cnt++; end
      bus.start = 1'b0; bus.annul = 1'b0;
      n_checks++; if (ready_cnt !== 0) begin n_fail++; $display("FAIL annul_idle_ignored: got %0d active cycles expected 0", ready_cnt); end
      @(posedge clk); #1;
      run_div(32'd9, 32'd3, 1'b0);
      n_checks++; if (r_lat !== 33) begin n_fail++; $display("FAIL annul_retry_latency: got %0d expected 33", r_lat); end
      n_checks++; if (r_res !== {32'd0, 32'd3}) begin n_fail++; $display("FAIL annul_retry_result: got %h expected %h", r_res, {32'd0, 32'd3}); end
   endtask

   task automatic test_async_reset();
      int ready_cnt = 0;
      bus.opdata1 = 32'd50; bus.opdata2 = 32'd5; bus.signed_div = 1'b0; bus.start = 1'b1;
      for (int i = 0; i < 5; i++) begin @(posedge clk); #1; end
      bus.start = 1'b0;
      #2; resetn = 1'b0; #1;
      n_checks++; if (bus.result !== 64'h0) begin n_fail++; $display("FAIL arst_result: got %h expected 0", bus.result); end
      n_checks++; if (bus.stallreq !== 1'b0) begin n_fail++; $display("FAIL arst_stall: got %b expected 0", bus.stallreq); end
      n_checks++; if (bus.ready !== 1'b0) begin n_fail++; $display("FAIL arst_ready: got %b expected 0", bus.ready); end
      #2; resetn = 1'b1;
      for (int i = 0; i < 40; i++) begin @(posedge clk); #1; if (bus.ready || bus.stallreq) ready_cnt++; end
      n_checks++; if (ready_cnt !== 0) begin n_fail++; $display("FAIL arst_spurious: got %0d active cycles expected 0", ready_cnt); end
   endtask

   task automatic test_back_to_back();
      logic [63:0] res1;
      int          lat1;
      logic        mid_ready;
      run_div(32'd50, 32'd5, 1'b0);
      res1 = r_res; lat1 = r_lat; mid_ready = r_ready_after;
      run_div(32'd50, 32'd6, 1'b0);
      n_checks++; if (res1 !== {32'd0, 32'd10}) begin n_fail++; $display("FAIL b2b_first: got %h expected %h", res1, {32'd0, 32'd10}); end
      n_checks++; if (lat1 !== 33) begin n_fail++; $display("FAIL b2b_first_latency: got %0d expected 33", lat1); end
      n_checks++; if (mid_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_gap_ready: got %b expected 0", mid_ready); end
      n_checks++; if (1 + r_lat !== 34) begin n_fail++; $display("FAIL b2b_spacing: got %0d expected 34", 1 + r_lat); end
      n_checks++; if (r_res !== {32'd2, 32'd8}) begin n_fail++; $display("FAIL b2b_second: got %h expected %h", r_res, {32'd2, 32'd8}); end
   endtask

   initial begin
      test_reset();
      test_unsigned();
      test_signed();
      test_div_zero();
      test_annul();
      test_async_reset();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
